// File: rtl/i2c_driver_arbiter.sv
// i2c_driver_arbiter: round-robin sharing of one I2C transceiver among several client controllers,
// with an inactivity watchdog that forces a STOP and reclaims the bus from a stalled owner.
package i2c_pkg;
    typedef struct packed {
        logic       tx_en;
        logic       rx_en;
        logic       start_en;
        logic       restart_en;
        logic       stop_en;
        logic       rx_ack;
        logic [7:0] tx_data;
    } i2c_in_t;
    typedef struct packed {
        logic       busy;
        logic       rx_valid;
        logic       ack_error;
        logic       arb_lost;
        logic [7:0] rx_data;
    } i2c_out_t;
    localparam i2c_in_t I2C_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    localparam i2c_in_t I2C_STOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
endpackage

module i2c_driver_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_CLIENTS-1:0]                   client_request,
    input  logic [NUM_CLIENTS-1:0]                   client_done,
    output logic [NUM_CLIENTS-1:0]                   client_ack,
    input  i2c_pkg::i2c_in_t [NUM_CLIENTS-1:0]       client_cin,
    output i2c_pkg::i2c_out_t                        client_cout,
    output i2c_pkg::i2c_in_t                         driver_cin,
    input  i2c_pkg::i2c_out_t                        driver_cout,
    output logic                                     owner_valid,
    output logic [$clog2(NUM_CLIENTS)-1:0]           owner_id,
    output logic                                     timeout,
    output logic [$clog2(NUM_CLIENTS)-1:0]           timeout_client
);
    import i2c_pkg::*;

    localparam int IW = $clog2(NUM_CLIENTS);
    localparam logic [1:0] S_IDLE = 2'd0, S_OWNED = 2'd1, S_ABORT = 2'd2, S_WAIT = 2'd3;
    localparam logic [NUM_CLIENTS-1:0] ONE = NUM_CLIENTS'(1);
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [1:0]             state;
    logic [NUM_CLIENTS-1:0] pending, req_all;
    logic [IW-1:0]          last_grant, winner;
    logic [23:0]            cnt;
    i2c_in_t                own_cin;
    logic                   own_active, own_done, expire;

    assign req_all     = pending | client_request;
    assign own_cin     = client_cin[owner_id];
    assign own_done    = client_done[owner_id];
    assign own_active  = own_cin.tx_en | own_cin.rx_en | own_cin.start_en | own_cin.restart_en | own_cin.stop_en;
    assign expire      = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST) && !own_active && !driver_cout.busy;
    assign client_cout = driver_cout;
    assign driver_cin  = state == S_OWNED ? own_cin : state == S_ABORT ? I2C_STOP : I2C_IDLE;

    // Iterating from the far end lets the nearest requester after last_grant overwrite the rest.
    always_comb begin
        logic [IW-1:0] idx;
        winner = '0;
        idx    = '0;
        for (int i = NUM_CLIENTS; i >= 1; i--) begin
            idx = IW'((int'(last_grant) + i) % NUM_CLIENTS);
            if (req_all[idx]) winner = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pending        <= '0;
            client_ack     <= '0;
            owner_valid    <= 1'b0;
            owner_id       <= '0;
            timeout        <= 1'b0;
            timeout_client <= '0;
            cnt            <= '0;
            last_grant     <= IW'(NUM_CLIENTS - 1);
        end else begin
            client_ack <= '0;
            timeout    <= 1'b0;
            pending    <= req_all;
            case (state)
                S_IDLE: if (|req_all) begin
                    state       <= S_OWNED;
                    client_ack  <= ONE << winner;
                    pending     <= req_all & ~(ONE << winner);
                    owner_valid <= 1'b1;
                    owner_id    <= winner;
                    last_grant  <= winner;
                    cnt         <= '0;
                end
                S_OWNED: if (own_done) begin
                    state       <= S_IDLE;
                    owner_valid <= 1'b0;
                    owner_id    <= '0;
                end else if (expire) begin
                    state          <= S_ABORT;
                    timeout        <= 1'b1;
                    timeout_client <= owner_id;
                end else begin
                    cnt <= (own_active || driver_cout.busy) ? '0 : cnt + 24'd1;
                end
                S_ABORT: state <= S_WAIT;
                default: if (!driver_cout.busy) begin
                    state       <= S_IDLE;
                    owner_valid <= 1'b0;
                    owner_id    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_driver_arbiter.sv
// tb_i2c_driver_arbiter: directed scenarios plus random traffic against a cycle-level ownership model;
// grants and timeouts flow through scoreboard queues checked by an independent monitor.
module tb_i2c_driver_arbiter;
    import i2c_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]     client_request = '0, client_done = '0, client_ack;
    i2c_in_t [N-1:0]  client_cin;
    i2c_out_t         client_cout, driver_cout;
    i2c_in_t          driver_cin;
    logic             owner_valid, timeout;
    logic [1:0]       owner_id, timeout_client;

    int compared = 0, mismatched = 0, cyc = 0;

    typedef struct { int cyc; int id; } ev_t;
    ev_t grant_q[$], to_q[$];
    ev_t mon_ev;

    // Reference model: phase 0 free, 1 owned, 2 stop being issued, 3 waiting for bus idle.
    int           m_phase = 0, m_owner = 0, m_ptr = N - 1, m_idle = 0, m_tclient = 0, m_w;
    logic [N-1:0] m_pend = '0, m_reqs;

    i2c_driver_arbiter #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .client_request(client_request), .client_done(client_done),
        .client_ack(client_ack), .client_cin(client_cin), .client_cout(client_cout),
        .driver_cin(driver_cin), .driver_cout(driver_cout), .owner_valid(owner_valid),
        .owner_id(owner_id), .timeout(timeout), .timeout_client(timeout_client)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic bad(input string name, input int act, input int exp);
        compared++;
        mismatched++;
        $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic busy_free(input i2c_in_t c);
        return !(c.tx_en || c.rx_en || c.start_en || c.restart_en || c.stop_en);
    endfunction

    function automatic i2c_in_t exp_drv();
        i2c_in_t c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        if (m_phase == 1) c = client_cin[m_owner];
        if (m_phase == 2) c.stop_en = 1'b1;
        return c;
    endfunction

    function automatic i2c_in_t rand_cin();
        i2c_in_t c;
        c.tx_data = 8'($urandom);
        c.rx_ack  = 1'($urandom);
        {c.tx_en, c.rx_en, c.start_en, c.restart_en, c.stop_en} =
            ($urandom_range(59) == 0) ? 5'(1 << $urandom_range(4)) : 5'd0;
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_ptr = N - 1; m_idle = 0; m_tclient = 0; m_pend = '0;
            grant_q.delete();
            to_q.delete();
        end else begin
            chk("owner_valid", owner_valid, m_phase != 0);
            chk("owner_id", owner_id, m_phase != 0 ? m_owner : 0);
            chk("driver_cin", driver_cin, exp_drv());
            chk("client_cout", client_cout, driver_cout);
            chk("timeout_client", timeout_client, m_tclient);
            m_reqs = m_pend | client_request;
            case (m_phase)
                0: if (m_reqs != '0) begin
                    m_w = pick(m_reqs, m_ptr);
                    grant_q.push_back('{cyc + 1, m_w});
                    m_owner = m_w; m_ptr = m_w; m_reqs[m_w] = 1'b0; m_phase = 1; m_idle = 0;
                end
                1: if (client_done[m_owner]) m_phase = 0;
                   else if (!busy_free(client_cin[m_owner]) || driver_cout.busy) m_idle = 0;
                   else if (++m_idle == TO) begin
                       m_phase = 2; m_tclient = m_owner;
                       to_q.push_back('{cyc + 1, m_owner});
                   end
                2: m_phase = 3;
                default: if (!driver_cout.busy) m_phase = 0;
            endcase
            m_pend = m_reqs;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (client_ack != '0) begin
                if (grant_q.size() == 0) bad("spurious_ack", int'(client_ack), 0);
                else begin
                    mon_ev = grant_q.pop_front();
                    chk("ack_cycle", cyc, mon_ev.cyc);
                    chk("ack_client", client_ack, 1 << mon_ev.id);
                end
            end else if (grant_q.size() != 0 && grant_q[0].cyc <= cyc) begin
                mon_ev = grant_q.pop_front();
                bad("missing_ack", -1, mon_ev.id);
            end
            if (timeout) begin
                if (to_q.size() == 0) bad("spurious_timeout", int'(timeout_client), -1);
                else begin
                    mon_ev = to_q.pop_front();
                    chk("timeout_cycle", cyc, mon_ev.cyc);
                    chk("timeout_id", timeout_client, mon_ev.id);
                end
            end else if (to_q.size() != 0 && to_q[0].cyc <= cyc) begin
                mon_ev = to_q.pop_front();
                bad("missing_timeout", -1, mon_ev.id);
            end
        end
    end

    task automatic pulse(input logic [N-1:0] req, input logic [N-1:0] done);
        client_request = req;
        client_done    = done;
        @(posedge clk);
        #1;
        client_request = '0;
        client_done    = '0;
    endtask

    task automatic wait_phase(input int ph, input string name);
        int n = 0;
        while (m_phase != ph && n < 60) begin pulse('0, '0); n++; end
        if (m_phase != ph) bad(name, m_phase, ph);
    endtask

    task automatic release_owner();
        wait_phase(1, "wait_owned");
        repeat (2) pulse('0, '0);
        pulse('0, N'(1) << m_owner);
    endtask

    initial begin
        for (int i = 0; i < N; i++) client_cin[i] = I2C_IDLE;
        driver_cout = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", client_ack, 0);
        chk("rst_owner_valid", owner_valid, 0);
        chk("rst_owner_id", owner_id, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_timeout_client", timeout_client, 0);
        chk("rst_driver_cin", driver_cin, I2C_IDLE);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // single request on idle bus at cycle 10
        while (cyc < 10) pulse('0, '0);
        client_cin[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5C};
        pulse(4'b0100, '0);
        repeat (3) pulse('0, '0);
        client_cin[2] = I2C_IDLE;
        pulse('0, 4'b0100);
        repeat (2) pulse('0, '0);
        // three simultaneous requesters served round robin
        pulse(4'b1011, '0);
        repeat (3) release_owner();
        repeat (2) pulse('0, '0);
        // non-owner commands and done are ignored
        pulse(4'b0010, '0);
        pulse('0, '0);
        client_cin[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA};
        pulse('0, 4'b0001);
        pulse('0, '0);
        chk("nonowner_tx_en", driver_cin.tx_en, 0);
        chk("owner_kept", owner_id, 1);
        client_cin[0] = I2C_IDLE;
        pulse('0, 4'b0010);
        repeat (2) pulse('0, '0);
        // watchdog abort of an idle owner
        pulse(4'b1000, '0);
        wait_phase(2, "wait_abort");
        driver_cout.busy = 1'b1;
        client_cin[3].start_en = 1'b1;
        pulse('0, 4'b1000);
        repeat (3) pulse('0, '0);
        driver_cout.busy = 1'b0;
        client_cin[3] = I2C_IDLE;
        repeat (2) pulse('0, '0);
        // done coincident with watchdog expiry wins
        pulse(4'b1000, '0);
        wait_phase(1, "wait_owned2");
        for (int n = 0; n < 60 && m_idle != TO - 1; n++) pulse('0, '0);
        pulse('0, 4'b1000);
        repeat (3) pulse('0, '0);
        // reset while the owner issues start
        pulse(4'b0001, '0);
        wait_phase(1, "wait_owned3");
        client_cin[0].start_en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_owner_valid", owner_valid, 0);
        chk("midrst_driver_cin", driver_cin, I2C_IDLE);
        chk("midrst_ack", client_ack, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        client_cin[0] = I2C_IDLE;
        pulse(4'b0100, '0);
        release_owner();
        repeat (2) pulse('0, '0);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) client_cin[i] = rand_cin();
            driver_cout.rx_data   = 8'($urandom);
            driver_cout.rx_valid  = 1'($urandom);
            driver_cout.ack_error = 1'($urandom);
            driver_cout.arb_lost  = 1'($urandom);
            driver_cout.busy      = driver_cout.busy ? ($urandom_range(2) != 0) : ($urandom_range(24) == 0);
            pulse(N'({$urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0}),
                  ((m_phase == 1 && $urandom_range(11) == 0) ? N'(1) << m_owner : N'(0)) |
                  (($urandom_range(29) == 0) ? N'(1) << $urandom_range(N - 1) : N'(0)));
        end
        driver_cout = '0;
        for (int i = 0; i < N; i++) client_cin[i] = I2C_IDLE;
        repeat (4) pulse('0, '0);
        chk("grant_q_drained", grant_q.size(), 0);
        chk("timeout_q_drained", to_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/i2c_driver_arbiter.md
I2C_DRIVER_ARBITER -- requirements
Module: i2c_driver_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4, number of I2C client controllers sharing one transceiver (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, owner-inactivity abort threshold in clk cycles; 0 disables the watchdog.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 client_request  input  NUM_CLIENTS  per-client one-cycle bus request pulse.
REQ-007 client_done  input  NUM_CLIENTS  per-client one-cycle bus release pulse.
REQ-008 client_ack  output  NUM_CLIENTS  per-client one-cycle grant pulse.
REQ-009 client_cin  input  NUM_CLIENTS x i2c_in_t  per-client transceiver commands.
REQ-010 client_cout  output  i2c_out_t  transceiver status, broadcast to all clients.
REQ-011 driver_cin  output  i2c_in_t  commands to the I2CTransceiver.
REQ-012 driver_cout  input  i2c_out_t  status from the I2CTransceiver.
REQ-013 owner_valid  output  1  high while a client holds the bus.
REQ-014 owner_id  output  $clog2(NUM_CLIENTS)  index of current owner; 0 when owner_valid low.
REQ-015 timeout  output  1  one-cycle pulse when an owner is forcibly released.
REQ-016 timeout_client  output  $clog2(NUM_CLIENTS)  index of the aborted client; holds until the next timeout.

Function
REQ-017 SHALL latch each client_request pulse into a pending bit; a pending bit clears only when that client is granted.
REQ-018 SHALL implement states IDLE, OWNED, ABORT, ABORT_WAIT.
REQ-019 IDLE: arbitration over (pending | client_request); winner = first set bit searching upward from last_grant+1 modulo NUM_CLIENTS.
REQ-020 On a win, next edge: client_ack[winner]=1 for exactly one cycle, owner_id=winner, owner_valid=1, last_grant=winner, state OWNED.
REQ-021 Grant latency SHALL be one cycle: a request pulse in cycle N on an idle bus yields client_ack in cycle N+1.
REQ-022 OWNED: driver_cin SHALL combinationally equal client_cin[owner_id]; other clients' client_cin SHALL be ignored.
REQ-023 When owner_valid is low, or in ABORT_WAIT, driver_cin SHALL be idle: all enables 0, rx_ack 1, tx_data 0.
REQ-024 client_done[owner_id] in OWNED SHALL return to IDLE next edge with owner_valid=0; arbitration resumes in that IDLE cycle (one idle cycle minimum between owners).
REQ-025 client_done from a non-owner SHALL be ignored; client_request from the current owner SHALL be latched as pending.
REQ-026 Watchdog counter (24 bits) SHALL clear on entry to OWNED, on any owner enable (tx_en, rx_en, start_en, restart_en, stop_en), and while driver_cout.busy is high; otherwise increments in OWNED.
REQ-027 When the counter reaches TIMEOUT_CYCLES (nonzero) SHALL go to ABORT: driver_cin.stop_en=1 for exactly that one cycle, other enables 0; timeout pulses the same cycle; timeout_client=owner_id.
REQ-028 ABORT SHALL go to ABORT_WAIT next edge; ABORT_WAIT SHALL go to IDLE on the first cycle driver_cout.busy is low, with owner_valid=0.
REQ-029 The aborted client's later client_done and client_cin SHALL be ignored.
REQ-030 client_done of the owner coincident with the timeout threshold SHALL take priority: normal release, no timeout pulse.
REQ-031 client_cout SHALL combinationally equal driver_cout.

Reset
REQ-032 While rst_n is low: state IDLE, pending 0, client_ack 0, owner_valid 0, owner_id 0, timeout 0, timeout_client 0, counter 0, last_grant NUM_CLIENTS-1, driver_cin idle per REQ-023.
REQ-033 Reset mid-transaction SHALL drop ownership immediately with no stop_en issued.

Verification
REQ-034 Idle bus, client 2 pulses request in cycle 10 -> client_ack[2] high in cycle 11 only, owner_id=2, driver_cin tracks client_cin[2].
REQ-035 Clients 0,1,3 pulse request in the same cycle after reset -> grants in order 0, 1, 3, each following the prior owner's done by 2 cycles.
REQ-036 Client 1 owns; client 0 drives tx_en=1, tx_data=8'hAA; client 0 pulses done -> driver_cin.tx_en stays 0; client 0's done ignored; client 1 stays owner.
REQ-037 TIMEOUT_CYCLES=16, owner 3 idle with busy low -> stop_en and timeout pulse in the 16th idle cycle, timeout_client=3; IDLE once busy is low again.
REQ-038 Owner done and watchdog expiry in the same cycle -> release, timeout stays 0, no stop_en.
REQ-039 rst_n low while owner issues start_en -> driver_cin idle and owner_valid 0 immediately; first request after reset is granted normally.
